// File: rtl/rs232_avm_pkg.sv
// Shared definitions for the RS232 Avalon-MM responder: register map,
// STATUS bit positions, widths and the bus FSM state type.
// Optional feature macro used by the top: RS232_AVM_ERR_EN.
package rs232_avm_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    localparam logic [ADDR_W-1:0] RX_BASE     = 5'd0;
    localparam logic [ADDR_W-1:0] TX_BASE     = 5'd4;
    localparam logic [ADDR_W-1:0] STATUS_BASE = 5'd8;

    localparam int unsigned TX_OK_BIT  = 6;
    localparam int unsigned RX_OK_BIT  = 7;
    localparam int unsigned TX_OVF_BIT = 8;
    localparam int unsigned RX_UDF_BIT = 9;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/rs232_avm_responder_byte_fifo.sv
// Small synchronous byte FIFO with registered occupancy count.
// Ports: clk, rst (sync, active-high); push/push_data write side; pop read
// side; full/empty/count status; head is the byte at the read pointer.
// DEPTH must be a power of two (pointers wrap by natural overflow).
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [7:0]       head,
    output logic [CNT_W-1:0] count
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage and pointers; memory is cleared so head reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rs232_avm_responder.sv
// Avalon-MM slave modelling a UART register window (RX at 0, TX at 4,
// STATUS at 8) backed by an RX byte FIFO fed from a stream and a TX byte
// FIFO drained to a stream. Each bus access takes one wait state plus one
// data cycle.
// Ports: avm_clk/avm_rst (sync, active-high); avm_* Avalon-MM slave;
// rx_valid/rx_data/rx_ready inbound byte stream; tx_valid/tx_data/tx_ready
// outbound byte stream.
// Optional macro RS232_AVM_ERR_EN adds sticky TX-overflow (bit 8) and
// RX-underflow (bit 9) flags in STATUS, cleared by a STATUS read.
module rs232_avm_responder
    import rs232_avm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    bus_state_e       state;
    logic             acc_rx_rd;
    logic             acc_tx_wr;
    logic [7:0]       wr_byte;
    logic [CNT_W-1:0] rx_count_q;
    logic [CNT_W-1:0] tx_count_q;

    logic             rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]       rx_head;
    logic [CNT_W-1:0] rx_count, tx_count;
    logic             rx_push, rx_pop, tx_push, tx_pop;
    logic [31:0]      status_word;
    logic [31:0]      read_mux;

    // Only the low byte of write data carries payload.
    logic unused_wdata;
    assign unused_wdata = ^avm_writedata[31:8];

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;
    assign rx_push  = rx_valid && rx_ready;
    assign tx_pop   = tx_valid && tx_ready;

    // Side effects commit in S_ACK using the occupancy captured in S_IDLE.
    assign rx_pop  = (state == S_ACK) && acc_rx_rd && (rx_count_q != '0);
    assign tx_push = (state == S_ACK) && acc_tx_wr && (tx_count_q != CNT_W'(FIFO_DEPTH));

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (avm_clk),
        .rst       (avm_rst),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head),
        .count     (rx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (avm_clk),
        .rst       (avm_rst),
        .push      (tx_push),
        .push_data (wr_byte),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_data),
        .count     (tx_count)
    );

`ifdef RS232_AVM_ERR_EN
    logic acc_status_rd;
    logic tx_ovf;
    logic rx_udf;
    logic ovf_evt;
    logic udf_evt;
    logic err_clr;

    assign ovf_evt = (state == S_ACK) && acc_tx_wr && (tx_count_q == CNT_W'(FIFO_DEPTH));
    assign udf_evt = (state == S_ACK) && acc_rx_rd && (rx_count_q == '0);
    assign err_clr = (state == S_ACK) && acc_status_rd;

    // Sticky error flags; a new event wins over the read-clear.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            tx_ovf        <= 1'b0;
            rx_udf        <= 1'b0;
            acc_status_rd <= 1'b0;
        end else begin
            if (ovf_evt) begin
                tx_ovf <= 1'b1;
            end else if (err_clr) begin
                tx_ovf <= 1'b0;
            end
            if (udf_evt) begin
                rx_udf <= 1'b1;
            end else if (err_clr) begin
                rx_udf <= 1'b0;
            end
            if (state == S_IDLE) begin
                acc_status_rd <= avm_read && (avm_address == STATUS_BASE);
            end else begin
                acc_status_rd <= 1'b0;
            end
        end
    end
`endif

    // STATUS word as seen in the S_IDLE cycle of an access.
    always_comb begin
        status_word            = '0;
        status_word[RX_OK_BIT] = !rx_empty;
        status_word[TX_OK_BIT] = !tx_full;
`ifdef RS232_AVM_ERR_EN
        status_word[TX_OVF_BIT] = tx_ovf;
        status_word[RX_UDF_BIT] = rx_udf;
`endif
    end

    always_comb begin
        read_mux = '0;
        if (avm_address == RX_BASE) begin
            read_mux = rx_empty ? 32'd0 : {24'd0, rx_head};
        end else if (avm_address == STATUS_BASE) begin
            read_mux = status_word;
        end
    end

    // Bus FSM: S_IDLE latches the access and read data, S_ACK releases the master.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state           <= S_IDLE;
            avm_waitrequest <= 1'b1;
            avm_readdata    <= '0;
            acc_rx_rd       <= 1'b0;
            acc_tx_wr       <= 1'b0;
            wr_byte         <= '0;
            rx_count_q      <= '0;
            tx_count_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    avm_waitrequest <= 1'b1;
                    if (avm_read || avm_write) begin
                        state           <= S_ACK;
                        avm_waitrequest <= 1'b0;
                        // Read wins when both strobes are high.
                        acc_rx_rd       <= avm_read && (avm_address == RX_BASE);
                        acc_tx_wr       <= !avm_read && avm_write && (avm_address == TX_BASE);
                        wr_byte         <= avm_writedata[7:0];
                        rx_count_q      <= rx_count;
                        tx_count_q      <= tx_count;
                        avm_readdata    <= avm_read ? read_mux : 32'd0;
                    end
                end
                S_ACK: begin
                    state           <= S_IDLE;
                    avm_waitrequest <= 1'b1;
                    acc_rx_rd       <= 1'b0;
                    acc_tx_wr       <= 1'b0;
                end
                default: begin
                    state           <= S_IDLE;
                    avm_waitrequest <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_avm_responder.sv
// Self-checking bench for rs232_avm_responder: directed bus/stream traffic
// with expected read data and TX bytes queued at issue time and compared by
// a monitor when the DUT presents them.
module tb_rs232_avm_responder;

    localparam logic [4:0] A_RX     = 5'd0;
    localparam logic [4:0] A_TX     = 5'd4;
    localparam logic [4:0] A_STATUS = 5'd8;
`ifdef RS232_AVM_ERR_EN
    localparam logic [31:0] OVF = 32'h0000_0100;
    localparam logic [31:0] UDF = 32'h0000_0200;
`else
    localparam logic [31:0] OVF = 32'h0;
    localparam logic [31:0] UDF = 32'h0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int cmp_count = 0;
    int err_count = 0;

    string       rd_name_q[$];
    logic [31:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];

    rs232_avm_responder #(.FIFO_DEPTH(4)) dut (
        .avm_clk         (clk),
        .avm_rst         (rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_ready        (rx_ready),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares read data on each read acknowledge and each TX byte taken.
    always @(negedge clk) begin
        string       nm;
        logic [31:0] ex;
        logic [7:0]  tb;
        if (!rst && avm_read && !avm_waitrequest) begin
            if (rd_exp_q.size() == 0) begin
                check32("unexpected_read_ack", avm_readdata, 32'hDEAD_BEEF);
            end else begin
                nm = rd_name_q.pop_front();
                ex = rd_exp_q.pop_front();
                check32(nm, avm_readdata, ex);
            end
        end
        if (!rst && tx_valid && tx_ready) begin
            if (tx_exp_q.size() == 0) begin
                check32("unexpected_tx_byte", 32'(tx_data), 32'hDEAD_BEEF);
            end else begin
                tb = tx_exp_q.pop_front();
                check32("tx_stream_byte", 32'(tx_data), 32'(tb));
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the acknowledge edge.
    task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        avm_address = addr;
        avm_read    = 1'b1;
        avm_write   = 1'b0;
        rd_name_q.push_back(name);
        rd_exp_q.push_back(exp);
        @(negedge clk);
        check32({name, "_wait"}, 32'(avm_waitrequest), 32'd1);
        @(negedge clk);
        check32({name, "_ack"}, 32'(avm_waitrequest), 32'd0);
        @(posedge clk);
        #1;
        avm_read = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [7:0] data, input string name);
        avm_address   = addr;
        avm_write     = 1'b1;
        avm_read      = 1'b0;
        avm_writedata = {24'hABCDEF, data};
        @(negedge clk);
        check32({name, "_wait"}, 32'(avm_waitrequest), 32'd1);
        @(negedge clk);
        check32({name, "_ack"}, 32'(avm_waitrequest), 32'd0);
        @(posedge clk);
        #1;
        avm_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        avm_address   = '0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        rx_valid      = 1'b0;
        rx_data       = '0;
        tx_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check32("rst_waitrequest", 32'(avm_waitrequest), 32'd1);
        check32("rst_readdata", avm_readdata, 32'd0);
        check32("rst_rx_ready", 32'(rx_ready), 32'd1);
        check32("rst_tx_valid", 32'(tx_valid), 32'd0);
        check32("rst_tx_data", 32'(tx_data), 32'd0);
        bus_read(A_STATUS, 32'h40, "status_after_reset");

        // One RX byte through the window
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        bus_read(A_STATUS, 32'hC0, "status_rx_ok");
        bus_read(A_RX, 32'hA5, "rx_read_a5");
        bus_read(A_STATUS, 32'h40, "status_rx_drained");

        // Fill TX with the stream stalled, then overflow
        bus_write(A_TX, 8'h11, "wr_11");
        check32("tx_valid_after_first_write", 32'(tx_valid), 32'd1);
        check32("tx_head_after_first_write", 32'(tx_data), 32'h11);
        bus_write(A_TX, 8'h22, "wr_22");
        bus_write(A_TX, 8'h33, "wr_33");
        bus_read(A_STATUS, 32'h40, "status_tx_three");
        bus_write(A_TX, 8'h44, "wr_44");
        bus_read(A_STATUS, 32'h00, "status_tx_full");
        bus_write(A_TX, 8'h55, "wr_55_dropped");
        bus_read(A_STATUS, OVF, "status_ovf_first");
        bus_read(A_STATUS, 32'h00, "status_ovf_cleared");

        // Drain TX
        tx_exp_q.push_back(8'h11);
        tx_exp_q.push_back(8'h22);
        tx_exp_q.push_back(8'h33);
        tx_exp_q.push_back(8'h44);
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check32("tx_valid_after_drain", 32'(tx_valid), 32'd0);
        check32("tx_bytes_all_seen", 32'(tx_exp_q.size()), 32'd0);

        // Fill RX from the stream, refuse a fifth byte
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'(i + 1);
            @(posedge clk);
            #1;
        end
        check32("rx_ready_full", 32'(rx_ready), 32'd0);
        rx_data = 8'h05;
        @(posedge clk);
        #1;
        check32("rx_ready_still_full", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
        bus_read(A_RX, 32'h01, "rx_read_01");
        check32("rx_ready_after_pop", 32'(rx_ready), 32'd1);
        bus_read(A_RX, 32'h02, "rx_read_02");
        bus_read(A_RX, 32'h03, "rx_read_03");
        bus_read(A_RX, 32'h04, "rx_read_04");
        bus_read(A_RX, 32'h00, "rx_read_empty");
        bus_read(A_STATUS, 32'h40 | UDF, "status_udf");

        // Empty RX read racing a push in its S_IDLE cycle
        rx_valid = 1'b1;
        rx_data  = 8'h7E;
        fork
            bus_read(A_RX, 32'h00, "rx_read_racing_push");
            begin
                @(posedge clk);
                #1;
                rx_valid = 1'b0;
            end
        join
        bus_read(A_RX, 32'h7E, "rx_read_7e");
        bus_read(A_STATUS, 32'h40 | UDF, "status_udf_race");

        // Reset during the data cycle of a TX write
        tx_ready      = 1'b0;
        avm_address   = A_TX;
        avm_writedata = 32'h99;
        avm_write     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        avm_write = 1'b0;
        check32("midreset_waitrequest", 32'(avm_waitrequest), 32'd1);
        check32("midreset_tx_valid", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check32("post_reset_tx_valid", 32'(tx_valid), 32'd0);
        bus_read(A_STATUS, 32'h40, "status_post_reset");

        repeat (3) @(posedge clk);
        #1;
        check32("read_queue_drained", 32'(rd_exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/rs232_avm_responder.md
# rs232_avm_responder

Avalon-MM slave that models the RS232 UART register window used by the RSA wrapper, so the wrapper can be simulated and tested without the vendor UART IP. It exposes RX, TX and STATUS registers on the memory-mapped side and two byte streams on the other side: an RX input stream that the bench or line receiver drives, and a TX output stream that the bench or line transmitter drains. Each direction is buffered in a small byte FIFO.

## Interface
- FIFO_DEPTH, 4: entries per byte FIFO; a power of two, at least 2.
- avm_clk  in  1  the only clock; all logic is on its rising edge.
- avm_rst  in  1  reset, synchronous and active-high.
- avm_address  in  5  byte address: 0 = RX, 4 = TX, 8 = STATUS.
- avm_read  in  1  read request.
- avm_readdata  out  32  read data; valid while avm_waitrequest is 0.
- avm_write  in  1  write request.
- avm_writedata  in  32  write data; only bits [7:0] are used.
- avm_waitrequest  out  1  high stalls the master.
- rx_valid  in  1  an RX byte is offered.
- rx_data  in  8  the RX byte.
- rx_ready  out  1  the RX FIFO is not full.
- tx_valid  out  1  the TX FIFO is not empty.
- tx_data  out  8  the TX FIFO head byte.
- tx_ready  in  1  the downstream side accepts tx_data.

## Operation
- Bus FSM has two states.
  - S_IDLE: avm_waitrequest=1. When avm_read or avm_write is high, latch the access, compute avm_readdata into a register, and go to S_ACK.
  - S_ACK: avm_waitrequest=0. Commit the side effect at the end of the cycle, then return to S_IDLE unconditionally.
- If read and write are both high, the access is treated as a read and the write is ignored.
- Read RX (0): readdata = {24'b0, RX head} if the RX FIFO is non-empty, otherwise 0.
  - The pop decision is latched in S_IDLE and the pop happens in S_ACK.
  - A push arriving during the access does not cause a pop.
- Read STATUS (8): bit 7 = RX FIFO non-empty (RX_OK); bit 6 = TX FIFO not full (TX_OK); all other bits 0 except as set under Configuration.
- Read TX or any unmapped address: returns 0, no side effect.
- Write TX (4): pushes writedata[7:0] if the TX FIFO is not full, judged by the count latched in S_IDLE. If full, the byte is dropped.
- Writes to RX, STATUS or unmapped addresses are ignored.
- RX stream: a byte is pushed when rx_valid && rx_ready. rx_ready = !rx_full, taken from the registered count.
- TX stream: a byte is popped when tx_valid && tx_ready.
- Each FIFO may push and pop in the same cycle; the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The count width is $clog2(FIFO_DEPTH)+1.

## Timing
- Reset values:
  - state=S_IDLE, avm_waitrequest=1, avm_readdata=0.
  - Both FIFOs empty, so rx_ready=1 and tx_valid=0.
  - tx_data=0.
- Every bus access takes exactly 2 cycles: 1 wait state plus 1 data cycle. Back-to-back accesses therefore sustain one access per 2 cycles.
- Readdata is registered; it reflects FIFO state sampled in the S_IDLE cycle of the access.
- FIFO latency: a byte pushed in cycle n is visible at the head, and in status, in cycle n+1.
  - An RX byte pushed at edge n sets STATUS bit 7 for a read whose S_IDLE cycle is n+1 or later.
  - A TX byte written in S_ACK at edge n raises tx_valid in cycle n+1.
- Reset mid-access: the access is abandoned with no pop and no push. Waitrequest is 1 on the next cycle.
- Status is not reserved for the caller: a master that checks TX_OK and then writes may still see its byte dropped if another write fills the FIFO first. A single master cannot hit this case.

## Configuration
- RS232_AVM_ERR_EN defined:
  - STATUS bit 8 = sticky TX overflow (a write was dropped).
  - STATUS bit 9 = sticky RX underflow (RX read while empty).
  - Both bits clear in the S_ACK cycle of a STATUS read. A new error event in that same cycle takes priority and sets the bit.
- Not defined: bits 8 and 9 read 0, and no sticky registers exist.

## Structure
- Package rs232_avm_pkg holds:
  - RX_BASE=0, TX_BASE=4, STATUS_BASE=8.
  - TX_OK_BIT=6, RX_OK_BIT=7, TX_OVF_BIT=8, RX_UDF_BIT=9.
  - The bus FSM state enum.
- One sub-module, byte_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/head/count), instantiated twice: RX and TX.

## Test plan
- Reset, then read STATUS → waitrequest 1 for one cycle, then readdata=0x00000040 (TX_OK only, RX empty).
- Push 0xA5 on RX, read STATUS, then read RX → 0x80|0x40=0xC0, then 0x000000A5; a following STATUS read gives 0x40.
- Write 0x11, 0x22, 0x33, 0x44 to TX with tx_ready=0 → STATUS bit 6 clears after the 4th write.
  - A 5th write of 0x55 is dropped.
  - Raise tx_ready → tx_data sequence 11, 22, 33, 44, then tx_valid=0.
- Push 4 RX bytes with no reads → rx_ready=0 and a 5th rx_valid byte is not taken.
  - Read RX once → rx_ready=1 the next cycle.
- Read RX while empty, with rx_valid pushing 0x7E in the S_IDLE cycle of that read → readdata=0 and 0x7E is not popped.
  - The next RX read returns 0x7E.
- With RS232_AVM_ERR_EN: overflow TX, then read STATUS twice → first read shows bit 8 set, second read shows it clear.
  - Assert avm_rst during an S_ACK write → TX FIFO stays empty.
